// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl
// Word-wide request/response front end for the asynchronous 16-bit cellular SRAM.
// One WORD_W-bit request is split into BEATS = WORD_W/16 consecutive 16-bit accesses,
// each with a one-cycle setup, WAIT_CYCLES of strobe and a one-cycle recovery.
// Beats with no enabled bytes on a write are skipped entirely.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; request captured on acceptance
//   req_we                1 = write, 0 = read
//   req_addr              word address
//   req_wdata, req_be     write data (beat 0 in the low 16 bits) and byte enables
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read data, held until the next read completes
//   busy                  controller not idle
//   data_sram             bidirectional SRAM data bus
//   addr2sram             SRAM address {req_addr, beat}
//   cs, we, oe, ub, lb    SRAM controls, active-low, all registered
module sram_word_ctrl #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned SRAM_AW     = 23,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_W-1:0]    req_wdata,
    input  logic [WORD_W/8-1:0]  req_be,
    output logic                 rsp_valid,
    output logic [WORD_W-1:0]    rsp_rdata,
    output logic                 busy,
    inout  wire  [15:0]          data_sram,
    output logic [SRAM_AW-1:0]   addr2sram,
    output logic                 cs,
    output logic                 we,
    output logic                 oe,
    output logic                 ub,
    output logic                 lb
);

    localparam int unsigned BEATS = WORD_W / 16;
    localparam int unsigned LOG_B = $clog2(BEATS);
    localparam int unsigned BIW   = (BEATS > 1) ? LOG_B : 1;
    localparam int unsigned BE_W  = WORD_W / 8;
    localparam int unsigned CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StRecover,
        StDone
    } state_t;

    state_t state_q, state_d;
    logic [BIW-1:0] beat_q, beat_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Captured request
    logic              op_we_q, op_we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [WORD_W-1:0] wdata_q, wdata_n;
    logic [BE_W-1:0]   be_q, be_n;

    // Registered SRAM-side outputs
    logic               cs_q, cs_d;
    logic               we_q, we_d;
    logic               oe_q, oe_d;
    logic               ub_q, ub_d;
    logic               lb_q, lb_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        dout_q, dout_d;
    logic               drive_q, drive_d;
    logic [WORD_W-1:0]  rdata_q, rdata_d;

    logic             accept;
    logic [BEATS-1:0] mask_n;
    logic             found;
    logic [BIW-1:0]   found_beat;
    int               search_from;
    int               next_slot;
    int               cur_slot;
    logic [1:0]       beat_be;

    always_comb begin
        accept = req_valid && (state_q == StIdle);

        // On the acceptance cycle the live inputs stand in for the not-yet-captured request
        op_we_n = accept ? req_we    : op_we_q;
        addr_n  = accept ? req_addr  : addr_q;
        wdata_n = accept ? req_wdata : wdata_q;
        be_n    = accept ? req_be    : be_q;

        for (int b = 0; b < int'(BEATS); b++) begin
            mask_n[b] = !op_we_n || (be_n[2*b +: 2] != 2'b00);
        end

        // Lowest active beat at or after the search point
        search_from = (state_q == StRecover) ? int'(beat_q) + 1 : 0;
        found       = 1'b0;
        found_beat  = '0;
        for (int i = int'(BEATS) - 1; i >= 0; i--) begin
            if (mask_n[i] && (i >= search_from)) begin
                found      = 1'b1;
                found_beat = BIW'(i);
            end
        end

        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (found) begin
                        state_d = StSetup;
                        beat_d  = found_beat;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = '0;
            end
            StAccess: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = StRecover;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRecover: begin
                if (found) begin
                    state_d = StSetup;
                    beat_d  = found_beat;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // SRAM outputs are derived from the next state so they line up with it once registered
        next_slot   = int'(beat_d);
        beat_be     = be_n[2*next_slot +: 2];
        cs_d        = 1'b1;
        we_d        = 1'b1;
        oe_d        = 1'b1;
        ub_d        = 1'b1;
        lb_d        = 1'b1;
        sram_addr_d = sram_addr_q;
        dout_d      = dout_q;
        drive_d     = 1'b0;
        if ((state_d == StSetup) || (state_d == StAccess)) begin
            cs_d = 1'b0;
            if (op_we_n) begin
                ub_d    = ~beat_be[1];
                lb_d    = ~beat_be[0];
                we_d    = (state_d != StAccess);
                drive_d = 1'b1;
                dout_d  = wdata_n[16*next_slot +: 16];
            end else begin
                oe_d = 1'b0;
                ub_d = 1'b0;
                lb_d = 1'b0;
            end
        end
        if (state_d == StSetup) begin
            sram_addr_d = (SRAM_AW'(addr_n) << LOG_B) | SRAM_AW'(beat_d);
        end
        // Hold write data through recovery for the SRAM's data hold time
        if ((state_d == StRecover) && op_we_n) begin
            drive_d = 1'b1;
        end

        // Read data is taken on the edge that ends the last strobe cycle
        cur_slot = int'(beat_q);
        rdata_d  = rdata_q;
        if ((state_q == StAccess) && !op_we_q && (cnt_q == LAST_CNT)) begin
            rdata_d[16*cur_slot +: 16] = data_sram;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cs_q        <= 1'b1;
            we_q        <= 1'b1;
            oe_q        <= 1'b1;
            ub_q        <= 1'b1;
            lb_q        <= 1'b1;
            sram_addr_q <= '0;
            dout_q      <= '0;
            drive_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            be_q        <= be_n;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            ub_q        <= ub_d;
            lb_q        <= lb_d;
            sram_addr_q <= sram_addr_d;
            dout_q      <= dout_d;
            drive_q     <= drive_d;
            rdata_q     <= rdata_d;
        end
    end

    assign data_sram = drive_q ? dout_q : 16'bz;
    assign addr2sram = sram_addr_q;
    assign cs        = cs_q;
    assign we        = we_q;
    assign oe        = oe_q;
    assign ub        = ub_q;
    assign lb        = lb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_valid = (state_q == StDone);
    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

endmodule
